// File: rtl/channel_entry_pkg.sv
// Shared definitions for the channel entry arbiter: default entry count,
// index-width helper and the grant lock state encoding.
package channel_entry_pkg;

    localparam int CHANNEL_ENTRY_NUM = 5;

    // Width of an entry index for n entries; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef enum logic {
        LOCK_IDLE   = 1'b0,
        LOCK_LOCKED = 1'b1
    } lock_state_e;

endpackage

// File: rtl/channel_entry_arb_rr_find_first.sv
// Rotate-and-first-find: picks the first set bit of valid_i at or after
// start_i, wrapping modulo N. Purely combinational.
module rr_find_first #(
    parameter int N = 5,
    parameter int W = 3
) (
    input  logic [N-1:0] valid_i,
    input  logic [W-1:0] start_i,
    output logic         found_o,
    output logic [W-1:0] index_o
);

    localparam logic [W:0] N_W = (W+1)'(N);

    // Candidates are formed in W+1 bits and folded back below N, so no
    // index at or beyond N is ever used to select a valid bit.
    always_comb begin
        logic [W:0] cand;
        found_o = 1'b0;
        index_o = start_i;
        cand    = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, start_i} + (W+1)'(k);
            if (cand >= N_W) begin
                cand = cand - N_W;
            end
            if (!found_o && valid_i[cand[W-1:0]]) begin
                found_o = 1'b1;
                index_o = cand[W-1:0];
            end
        end
    end

endmodule

// File: rtl/channel_entry_arb.sv
// Round-robin arbiter over channel entries with valid/ready grant handshake.
// Define CHANNEL_ENTRY_ARB_HOLD_EN to keep a stalled grant stable (lock FSM).
module channel_entry_arb
    import channel_entry_pkg::*;
#(
    parameter int NUM_ENTRY = CHANNEL_ENTRY_NUM,
    parameter int ID_W      = id_width(NUM_ENTRY)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_ENTRY-1:0] entry_valid_i,
    input  logic                 grant_ready_i,
    output logic                 grant_valid_o,
    output logic [ID_W-1:0]      grant_id_o,
    output logic [NUM_ENTRY-1:0] grant_onehot_o,
    output logic [ID_W-1:0]      read_ptr_o,
    output lock_state_e          lock_state_o
);

    // Grant handshake: a grant transfers in any cycle where grant_valid_o and
    // grant_ready_i are both high; the pointer advances only on that cycle.

    localparam logic [ID_W:0] N_W = (ID_W+1)'(NUM_ENTRY);

    logic [ID_W-1:0] read_ptr_q;
    logic [ID_W-1:0] read_ptr_d;
    logic [ID_W:0]   ptr_sum;
    logic            find_found;
    logic [ID_W-1:0] find_idx;
    logic            arb_valid;
    logic [ID_W-1:0] arb_id;
    logic            handshake;

    rr_find_first #(
        .N (NUM_ENTRY),
        .W (ID_W)
    ) u_find (
        .valid_i (entry_valid_i),
        .start_i (read_ptr_q),
        .found_o (find_found),
        .index_o (find_idx)
    );

`ifdef CHANNEL_ENTRY_ARB_HOLD_EN
    lock_state_e     state_q;
    lock_state_e     state_d;
    logic [ID_W-1:0] lock_id_q;
    logic [ID_W-1:0] lock_id_d;
    logic            lock_hit;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= LOCK_IDLE;
            lock_id_q <= '0;
        end else begin
            state_q   <= state_d;
            lock_id_q <= lock_id_d;
        end
    end

    // A held grant survives only while its entry still requests; once it
    // drops, the normal search result is presented in the same cycle.
    always_comb begin
        lock_hit  = (state_q == LOCK_LOCKED) && entry_valid_i[lock_id_q];
        arb_valid = lock_hit | find_found;
        arb_id    = lock_hit ? lock_id_q : find_idx;
        state_d   = LOCK_IDLE;
        lock_id_d = lock_id_q;
        if (arb_valid && !grant_ready_i) begin
            state_d   = LOCK_LOCKED;
            lock_id_d = arb_id;
        end
    end

    assign lock_state_o = state_q;
`else
    always_comb begin
        arb_valid = find_found;
        arb_id    = find_idx;
    end

    assign lock_state_o = LOCK_IDLE;
`endif

    assign handshake = arb_valid & grant_ready_i;

    always_comb begin
        ptr_sum = {1'b0, arb_id} + (ID_W+1)'(1);
        if (ptr_sum >= N_W) begin
            ptr_sum = ptr_sum - N_W;
        end
        read_ptr_d = handshake ? ptr_sum[ID_W-1:0] : read_ptr_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            read_ptr_q <= '0;
        end else begin
            read_ptr_q <= read_ptr_d;
        end
    end

    // Outputs are forced quiet while reset is held, whatever the requests.
    always_comb begin
        grant_valid_o = arb_valid & ~rst_i;
        grant_id_o    = rst_i ? '0 : arb_id;
        read_ptr_o    = rst_i ? '0 : read_ptr_q;
        for (int k = 0; k < NUM_ENTRY; k++) begin
            grant_onehot_o[k] = grant_valid_o && (arb_id == ID_W'(k));
        end
    end

endmodule

// File: tb/tb_channel_entry_arb.sv
// Bench for channel_entry_arb: instances with 5, 8 and 3 entries checked
// every cycle against a queue/modulo model, plus literal directed grants.
module tb_channel_entry_arb;
    import channel_entry_pkg::*;

`ifdef CHANNEL_ENTRY_ARB_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [4:0] v5;
    logic [7:0] v8;
    logic [2:0] v3;
    logic       r5, r8, r3;

    logic        gv5, gv8, gv3;
    logic [2:0]  gid5, gid8;
    logic [1:0]  gid3;
    logic [4:0]  oh5;
    logic [7:0]  oh8;
    logic [2:0]  oh3;
    logic [2:0]  ptr5, ptr8;
    logic [1:0]  ptr3;
    lock_state_e ls5, ls8, ls3;

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q[$];

    logic [15:0] mv[3];
    logic        mr[3];
    logic        dgv[3];
    int          dgid[3];
    logic [15:0] doh[3];
    int          dptr[3];
    int          m_ptr[3];
    int          m_lock[3];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    channel_entry_arb #(.NUM_ENTRY(5)) u_dut5 (
        .clk_i(clk), .rst_i(rst), .entry_valid_i(v5), .grant_ready_i(r5),
        .grant_valid_o(gv5), .grant_id_o(gid5), .grant_onehot_o(oh5),
        .read_ptr_o(ptr5), .lock_state_o(ls5)
    );

    channel_entry_arb #(.NUM_ENTRY(8)) u_dut8 (
        .clk_i(clk), .rst_i(rst), .entry_valid_i(v8), .grant_ready_i(r8),
        .grant_valid_o(gv8), .grant_id_o(gid8), .grant_onehot_o(oh8),
        .read_ptr_o(ptr8), .lock_state_o(ls8)
    );

    channel_entry_arb #(.NUM_ENTRY(3)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .entry_valid_i(v3), .grant_ready_i(r3),
        .grant_valid_o(gv3), .grant_id_o(gid3), .grant_onehot_o(oh3),
        .read_ptr_o(ptr3), .lock_state_o(ls3)
    );

    always_comb begin
        mv[0] = {11'b0, v5};  mr[0] = r5;
        mv[1] = {8'b0, v8};   mr[1] = r8;
        mv[2] = {13'b0, v3};  mr[2] = r3;
        dgv[0] = gv5;  dgid[0] = {29'b0, gid5};  doh[0] = {11'b0, oh5};  dptr[0] = {29'b0, ptr5};
        dgv[1] = gv8;  dgid[1] = {29'b0, gid8};  doh[1] = {8'b0, oh8};   dptr[1] = {29'b0, ptr8};
        dgv[2] = gv3;  dgid[2] = {30'b0, gid3};  doh[2] = {13'b0, oh3};  dptr[2] = {30'b0, ptr3};
    end

    // ---------------- reference model ----------------
    function automatic int n_of(input int i);
        return (i == 0) ? 5 : ((i == 1) ? 8 : 3);
    endfunction

    // Held entry wins while it still requests; otherwise first requester
    // found walking up from the pointer, modulo n. Idle grant id = pointer.
    function automatic void model_grant(input int n, input logic [15:0] v,
                                        input int ptr, input int lock,
                                        output logic gv, output int gid);
        gv  = 1'b0;
        gid = ptr;
        if (lock >= 0 && v[lock]) begin
            gv  = 1'b1;
            gid = lock;
        end else begin
            for (int k = 0; k < n; k++) begin
                int idx;
                idx = (ptr + k) % n;
                if (!gv && v[idx]) begin
                    gv  = 1'b1;
                    gid = idx;
                end
            end
        end
    endfunction

    always @(posedge clk or posedge rst) begin : model_upd
        logic mgv;
        int   mgid;
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_ptr[i]  <= 0;
                m_lock[i] <= -1;
            end else begin
                model_grant(n_of(i), mv[i], m_ptr[i], m_lock[i], mgv, mgid);
                if (mgv && mr[i]) begin
                    m_ptr[i]  <= (mgid + 1) % n_of(i);
                    m_lock[i] <= -1;
                end else if (mgv && HOLD) begin
                    m_lock[i] <= mgid;
                end else begin
                    m_lock[i] <= -1;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : cmp
        logic        egv;
        int          egid;
        logic [15:0] eoh;
        int          eptr;
        logic [7:0]  e;
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                egv = 1'b0; egid = 0; eoh = '0; eptr = 0;
            end else begin
                model_grant(n_of(i), mv[i], m_ptr[i], m_lock[i], egv, egid);
                eoh  = egv ? (16'd1 << egid) : 16'd0;
                eptr = m_ptr[i];
            end
            check($sformatf("n%0d grant_valid", n_of(i)), {31'b0, dgv[i]}, {31'b0, egv});
            check($sformatf("n%0d grant_id", n_of(i)), dgid[i], egid);
            check($sformatf("n%0d grant_onehot", n_of(i)), {16'b0, doh[i]}, {16'b0, eoh});
            check($sformatf("n%0d read_ptr", n_of(i)), dptr[i], eptr);
        end
        if (!rst && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e != 8'hFF) check("n5 directed grant_id", dgid[0], {24'b0, e});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set5(input logic [4:0] v, input logic r, input int exp_id);
        @(posedge clk);
        #1;
        v5 = v;
        r5 = r;
        exp_q.push_back((exp_id < 0) ? 8'hFF : 8'(exp_id));
    endtask

    initial begin
        v5 = '0; v8 = '0; v3 = '0;
        r5 = 1'b0; r8 = 1'b0; r3 = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // two requesters, pointer advances past each grant
        set5(5'b10100, 1'b1, 2);
        check("n5 ptr after reset", dptr[0], 0);
        set5(5'b10100, 1'b1, 4);
        check("n5 ptr after grant 2", dptr[0], 3);
        set5(5'b00000, 1'b0, 0);
        check("n5 ptr wrap after grant 4", dptr[0], 0);
        #1 check("n5 empty grant_valid", {31'b0, gv5}, 0);

        // wrap search from pointer 4
        set5(5'b01000, 1'b1, 3);
        set5(5'b00011, 1'b1, 0);
        check("n5 ptr before wrap", dptr[0], 4);
        set5(5'b00000, 1'b0, 1);
        check("n5 ptr after wrap grant", dptr[0], 1);
        set5(5'b10000, 1'b1, 4);

        // fairness over all-ones
        for (int c = 0; c < 10; c++) set5(5'b11111, 1'b1, c % 5);

        // stall behaviour
        set5(5'b01000, 1'b0, 3);
        check("n5 ptr before stall", dptr[0], 0);
`ifdef CHANNEL_ENTRY_ARB_HOLD_EN
        set5(5'b01001, 1'b0, 3);
        check("n5 lock state", int'(ls5), int'(LOCK_LOCKED));
        set5(5'b00001, 1'b0, 0);
        set5(5'b00001, 1'b1, 0);
`else
        set5(5'b01001, 1'b0, 0);
        check("n5 lock state", int'(ls5), int'(LOCK_IDLE));
        set5(5'b01001, 1'b1, 0);
`endif
        set5(5'b00000, 1'b0, 1);
        check("n5 ptr after stall release", dptr[0], 1);

        // reset in the middle of a stall
        set5(5'b00010, 1'b1, 1);
        set5(5'b11000, 1'b0, 3);
        check("n5 ptr before reset", dptr[0], 2);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("n5 reset grant_valid", {31'b0, gv5}, 0);
        check("n5 reset grant_id", dgid[0], 0);
        check("n5 reset onehot", {16'b0, doh[0]}, 0);
        check("n5 reset read_ptr", dptr[0], 0);
        v5 = '0;
        @(posedge clk);
        #2 rst = 1'b0;
        check("n5 ptr after reset release", dptr[0], 0);
        set5(5'b11001, 1'b1, 0);

        // random traffic on all three sizes
        repeat (300) begin
            @(posedge clk);
            #1;
            v5 = 5'($urandom_range(0, 31));
            v8 = 8'($urandom_range(0, 255));
            v3 = 3'($urandom_range(0, 7));
            r5 = ($urandom_range(0, 3) != 0);
            r8 = ($urandom_range(0, 3) != 0);
            r3 = ($urandom_range(0, 2) != 0);
        end
        @(posedge clk);
        #1;
        v5 = '0; v8 = '0; v3 = '0;
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
